// File: rtl/basic_package.sv
// Shared types for the layer scheduler: FSM states
// and the per-layer descriptor record.
package basic_package;

  localparam int DEF_PA  = 8;
  localparam int DEF_PW  = 4;
  localparam int DEF_MNO = 288;
  localparam int DEF_MNV = 224 * 224;
  localparam int DEF_NL  = 8;

  localparam int WD = $clog2(DEF_MNO);
  localparam int WQ = $clog2(DEF_PA * DEF_PW);
  localparam int WV = $clog2(DEF_MNV);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    FIN
  } sched_state_t;

  typedef struct packed {
    logic [WD-1:0] done;
    logic [WQ-1:0] quant;
    logic [2:0]    out;
    logic [2:0]    relu;
    logic [2:0]    fil;
    logic [WV-1:0] vol;
  } layer_cfg_t;

endpackage

// File: rtl/layer_sched_if.sv
// Config, control and descriptor-output bundle
// between the host/datapath and the scheduler.
interface layer_sched_if #(
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  parameter int MNV = 224 * 224,
  parameter int NL  = 8
);
  localparam int WI = $clog2(NL);
  localparam int WD = $clog2(MNO);
  localparam int WQ = $clog2(Pa * Pw);
  localparam int WV = $clog2(MNV);

  logic          cfg_wr;
  logic [WI-1:0] cfg_idx;
  logic [WD-1:0] cfg_done;
  logic [WQ-1:0] cfg_quant;
  logic [2:0]    cfg_out;
  logic [2:0]    cfg_relu;
  logic [2:0]    cfg_fil;
  logic [WV-1:0] cfg_vol;
  logic [WI:0]   num_layers;
  logic          start;
  logic          abort;
  logic          layer_end;

  logic          core_stall_n;
  logic [WD-1:0] max_val_cnt_done;
  logic [WQ-1:0] max_val_cnt_quant;
  logic [2:0]    max_val_cnt_out;
  logic [2:0]    max_val_cnt_relu;
  logic [2:0]    max_val_fil_group;
  logic [WV-1:0] max_val_in_vol;
  logic [WI-1:0] cur_layer;
  logic          busy;
  logic          layer_done;
  logic          all_done;

  modport master (
    output cfg_wr, cfg_idx, cfg_done, cfg_quant,
    output cfg_out, cfg_relu, cfg_fil, cfg_vol,
    output num_layers, start, abort, layer_end,
    input  core_stall_n, max_val_cnt_done,
    input  max_val_cnt_quant, max_val_cnt_out,
    input  max_val_cnt_relu, max_val_fil_group,
    input  max_val_in_vol, cur_layer, busy,
    input  layer_done, all_done
  );

  modport slave (
    input  cfg_wr, cfg_idx, cfg_done, cfg_quant,
    input  cfg_out, cfg_relu, cfg_fil, cfg_vol,
    input  num_layers, start, abort, layer_end,
    output core_stall_n, max_val_cnt_done,
    output max_val_cnt_quant, max_val_cnt_out,
    output max_val_cnt_relu, max_val_fil_group,
    output max_val_in_vol, cur_layer, busy,
    output layer_done, all_done
  );

endinterface

// File: rtl/layer_cfg_rf.sv
// Layer descriptor storage: flop array with one
// synchronous write port and one async read port.
module layer_cfg_rf
  import basic_package::*;
#(
  parameter int NL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [$clog2(NL)-1:0] waddr_i,
  input  layer_cfg_t         wdata_i,
  input  logic [$clog2(NL)-1:0] raddr_i,
  output layer_cfg_t         rdata_o
);

  layer_cfg_t mem_q [NL];

  // write one slot; reset clears every slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: loads each layer descriptor,
// lets it settle, then releases the core per layer.
module layer_sched
  import basic_package::*;
#(
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  parameter int MNV = 224 * 224,
  parameter int NL  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  layer_sched_if.slave bus
);

  localparam int WI = $clog2(NL);
  localparam logic [WI:0]   NL_C  = (WI+1)'(NL);
  localparam logic [WI:0]   ONE_C = (WI+1)'(1);
  localparam logic [WI-1:0] INC_C = WI'(1);

  sched_state_t  state_q, state_d;
  logic [WI-1:0] cur_q, cur_d;
  logic [WI:0]   cnt_q, cnt_d;
  layer_cfg_t    mv_q, mv_d;
  layer_cfg_t    wcfg, rcfg;
  logic          stall_n_q, stall_n_d;
  logic          busy_q, busy_d;
  logic          ld_q, ld_d;
  logic          ad_q, ad_d;

  assign wcfg.done  = bus.cfg_done;
  assign wcfg.quant = bus.cfg_quant;
  assign wcfg.out   = bus.cfg_out;
  assign wcfg.relu  = bus.cfg_relu;
  assign wcfg.fil   = bus.cfg_fil;
  assign wcfg.vol   = bus.cfg_vol;

  layer_cfg_rf #(.NL(NL)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.cfg_wr),
    .waddr_i (bus.cfg_idx),
    .wdata_i (wcfg),
    .raddr_i (cur_q),
    .rdata_o (rcfg)
  );

  // next state, layer index and registered outputs
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    mv_d    = mv_q;
    ld_d    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_layers != '0) begin
              cur_d   = '0;
              cnt_d   = (bus.num_layers > NL_C) ?
                        NL_C : bus.num_layers;
              state_d = LOAD;
            end else begin
              state_d = FIN;
            end
          end
        end
        LOAD: begin
          mv_d    = rcfg;
          state_d = SETTLE;
        end
        SETTLE: state_d = RUN;
        RUN: begin
          if (bus.layer_end) begin
            ld_d = 1'b1;
            if ({1'b0, cur_q} == cnt_q - ONE_C) begin
              state_d = FIN;
            end else begin
              cur_d   = cur_q + INC_C;
              state_d = LOAD;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    stall_n_d = (state_d == RUN);
    busy_d    = (state_d == LOAD) ||
                (state_d == SETTLE) ||
                (state_d == RUN);
    ad_d      = (state_d == FIN);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      mv_q      <= '0;
      stall_n_q <= 1'b0;
      busy_q    <= 1'b0;
      ld_q      <= 1'b0;
      ad_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      mv_q      <= mv_d;
      stall_n_q <= stall_n_d;
      busy_q    <= busy_d;
      ld_q      <= ld_d;
      ad_q      <= ad_d;
    end
  end

  assign bus.core_stall_n      = stall_n_q;
  assign bus.busy              = busy_q;
  assign bus.layer_done        = ld_q;
  assign bus.all_done          = ad_q;
  assign bus.cur_layer         = cur_q;
  assign bus.max_val_cnt_done  = mv_q.done;
  assign bus.max_val_cnt_quant = mv_q.quant;
  assign bus.max_val_cnt_out   = mv_q.out;
  assign bus.max_val_cnt_relu  = mv_q.relu;
  assign bus.max_val_fil_group = mv_q.fil;
  assign bus.max_val_in_vol    = mv_q.vol;

endmodule

// File: tb/tb_layer_sched.sv
// Randomised bench for layer_sched against a
// descriptor-table model of the layer sequence.
module tb_layer_sched;
  import basic_package::*;

  localparam int NL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_sched_if #(
    .Pa(8), .Pw(4), .MNO(288), .MNV(224*224), .NL(NL)
  ) bus ();

  layer_sched #(
    .Pa(8), .Pw(4), .MNO(288), .MNV(224*224), .NL(NL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  layer_cfg_t m_slot [NL];

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {bus.busy, bus.core_stall_n,
            bus.layer_done, bus.all_done};
  endfunction

  function automatic logic [63:0] outs_cfg();
    return 64'({bus.max_val_cnt_done, bus.max_val_cnt_quant,
                bus.max_val_cnt_out, bus.max_val_cnt_relu,
                bus.max_val_fil_group, bus.max_val_in_vol});
  endfunction

  function automatic layer_cfg_t rand_cfg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[$bits(layer_cfg_t)-1:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.cfg_wr = 0; bus.cfg_idx = '0;
    bus.cfg_done = '0; bus.cfg_quant = '0;
    bus.cfg_out = '0; bus.cfg_relu = '0;
    bus.cfg_fil = '0; bus.cfg_vol = '0;
    bus.num_layers = '0; bus.start = 0;
    bus.abort = 0; bus.layer_end = 0;
  endtask

  task automatic drive_wr(int idx, layer_cfg_t c);
    bus.cfg_wr = 1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_done = c.done;
    bus.cfg_quant = c.quant;
    bus.cfg_out = c.out;
    bus.cfg_relu = c.relu;
    bus.cfg_fil = c.fil;
    bus.cfg_vol = c.vol;
  endtask

  task automatic wr_slot(int idx, layer_cfg_t c);
    drive_wr(idx, c);
    cyc();
    bus.cfg_wr = 0;
    m_slot[idx] = c;
  endtask

  // abort now; scheduler must be idle and silent after
  task automatic do_abort(string tag);
    bus.abort = 1;
    bus.layer_end = 1;
    cyc();
    clr_in();
    chk({tag, "_ctl"}, 64'(ctl()), 64'(4'b0000));
    cyc();
    chk({tag, "_idle"}, 64'(ctl()), 64'(4'b0000));
  endtask

  // ab_at: -2 abort in LOAD, -1 in SETTLE, k>=0 in RUN
  task automatic run(int n, int len, int ab_layer,
                     int ab_at, int wr_layer);
    int eff;
    layer_cfg_t exp_c, nv;
    eff = (n > NL) ? NL : n;
    bus.num_layers = 4'(n);
    bus.start = 1;
    cyc();
    bus.start = 0;
    if (eff == 0) begin
      chk("zero_go", 64'(ctl()), 64'(4'b0001));
      cyc();
      chk("zero_end", 64'(ctl()), 64'(4'b0000));
      return;
    end
    for (int L = 0; L < eff; L++) begin
      chk("load_ctl", 64'(ctl()),
          64'({2'b10, L != 0, 1'b0}));
      chk("load_idx", 64'(bus.cur_layer), 64'(L));
      if (L == ab_layer && ab_at == -2) begin
        do_abort("ab_load");
        return;
      end
      exp_c = m_slot[L];
      bus.layer_end = 1'($urandom_range(0, 1));
      cyc();
      bus.layer_end = 0;
      chk("settle_ctl", 64'(ctl()), 64'(4'b1000));
      chk("settle_cfg", outs_cfg(), 64'(exp_c));
      if (L == ab_layer && ab_at == -1) begin
        do_abort("ab_settle");
        return;
      end
      bus.layer_end = 1'($urandom_range(0, 1));
      cyc();
      bus.layer_end = 0;
      for (int k = 0; k < len; k++) begin
        chk("run_ctl", 64'(ctl()), 64'(4'b1100));
        chk("run_cfg", outs_cfg(), 64'(exp_c));
        if (L == ab_layer && k == ab_at) begin
          do_abort("ab_run");
          return;
        end
        bus.start = ($urandom_range(0, 3) == 0);
        if (L == wr_layer && k == 0) begin
          nv = rand_cfg();
          nv.done = 9'd99;
          drive_wr(L, nv);
          m_slot[L] = nv;
        end
        cyc();
        bus.start = 0;
        bus.cfg_wr = 0;
      end
      bus.layer_end = 1;
      cyc();
      bus.layer_end = 0;
    end
    chk("fin_ctl", 64'(ctl()), 64'(4'b0011));
    cyc();
    chk("idle_ctl", 64'(ctl()), 64'(4'b0000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    layer_cfg_t c;
    int n, len, abl, aba, wrl;
    clr_in();
    for (int i = 0; i < NL; i++) m_slot[i] = '0;
    #1;
    chk("rst_ctl", 64'(ctl()), 64'(4'b0000));
    chk("rst_cfg", outs_cfg(), 64'(0));
    chk("rst_idx", 64'(bus.cur_layer), 64'(0));
    cyc();
    cyc();
    rst_n = 1;
    cyc();

    for (int i = 0; i < 3; i++) begin
      c = rand_cfg();
      c.done = 9'(10 * (i + 1));
      wr_slot(i, c);
    end
    run(3, 50, -1, 0, -1);

    run(0, 1, -1, 0, -1);

    for (int i = 0; i < 2; i++) begin
      bus.num_layers = 4'(2 * i);
      bus.start = 1;
      bus.abort = 1;
      cyc();
      clr_in();
      chk("ab_start", 64'(ctl()), 64'(4'b0000));
      cyc();
      chk("ab_start2", 64'(ctl()), 64'(4'b0000));
    end

    run(3, 5, 1, 2, -1);
    run(2, 4, -1, 0, 1);
    run(2, 3, -1, 0, -1);

    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < $urandom_range(0, 4); w++)
        wr_slot($urandom_range(0, NL - 1), rand_cfg());
      n   = $urandom_range(0, 10);
      len = $urandom_range(1, 6);
      abl = ($urandom_range(0, 3) == 0) ?
            $urandom_range(0, 7) : -1;
      aba = $urandom_range(0, len + 1) - 2;
      wrl = ($urandom_range(0, 3) == 0) ?
            $urandom_range(0, 7) : -1;
      run(n, len, abl, aba, wrl);
    end

    wr_slot(0, rand_cfg());
    wr_slot(1, rand_cfg());
    bus.num_layers = 4'd2;
    bus.start = 1;
    cyc();
    bus.start = 0;
    cyc();
    cyc();
    cyc();
    bus.layer_end = 1;
    cyc();
    bus.layer_end = 0;
    cyc();
    cyc();
    chk("pre_rst", 64'(ctl()), 64'(4'b1100));
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_ctl", 64'(ctl()), 64'(4'b0000));
    chk("mid_rst_cfg", outs_cfg(), 64'(0));
    chk("mid_rst_idx", 64'(bus.cur_layer), 64'(0));
    for (int i = 0; i < NL; i++) m_slot[i] = '0;
    cyc();
    rst_n = 1;
    cyc();
    run(2, 2, -1, 0, -1);
    wr_slot(0, rand_cfg());
    wr_slot(1, rand_cfg());
    run(2, 3, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 Parameter Pa, default 8, activation bit precision, matching the CTRL unit.
REQ-002 Parameter Pw, default 4, weight bit precision.
REQ-003 Parameter MNO, default 288, maximum operations per output.
REQ-004 Parameter MNV, default 224*224, maximum input-volume count.
REQ-005 Parameter NL, default 8, number of layer-descriptor slots.
REQ-006 Ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_wr  input  1  write descriptor slot cfg_idx.
- cfg_idx  input  $clog2(NL)  slot address.
- cfg_done, cfg_quant, cfg_out, cfg_relu, cfg_fil, cfg_vol  input  widths equal to the matching max_val_* outputs  descriptor fields.
- num_layers  input  $clog2(NL)+1  layer count, sampled at start.
- start  input  1  begin a run.
- abort  input  1  kill the run.
- layer_end  input  1  one-cycle pulse from the datapath: current layer finished.
- core_stall_n  output  1  release to the CTRL unit; 1 = run.
- max_val_cnt_done  output  $clog2(MNO)
- max_val_cnt_quant  output  $clog2(Pa*Pw)
- max_val_cnt_out, max_val_cnt_relu, max_val_fil_group  output  3 each
- max_val_in_vol  output  $clog2(MNV)
- cur_layer  output  $clog2(NL)  index of the active layer.
- busy  output  1  run in progress.
- layer_done  output  1  one-cycle pulse per completed layer.
- all_done  output  1  one-cycle pulse at run end.

Function
REQ-007 The FSM SHALL have the states IDLE, LOAD, SETTLE, RUN and FIN.
REQ-008 IDLE: on start with num_layers != 0, set cur_layer=0, latch num_layers (clamped to NL), go to LOAD; on start with num_layers == 0, go to FIN.
REQ-009 LOAD (1 cycle): register slot[cur_layer] onto all max_val_* outputs, then go to SETTLE.
REQ-010 SETTLE (1 cycle): max_val_* held stable, core_stall_n=0, then go to RUN; core_stall_n rises exactly 2 cycles after LOAD entry.
REQ-011 RUN: core_stall_n=1; on layer_end, pulse layer_done for 1 cycle.
- If cur_layer == latched count-1: go to FIN.
- Otherwise: increment cur_layer and go to LOAD.
REQ-012 core_stall_n SHALL be 0 in every state except RUN, and registered (no combinational path from the inputs).
REQ-013 FIN: pulse all_done for 1 cycle, then go to IDLE.
REQ-014 busy=1 in LOAD, SETTLE and RUN; busy=0 in IDLE and FIN.
REQ-015 start while busy SHALL be ignored.
REQ-016 layer_end outside RUN SHALL be ignored.
REQ-017 abort in any state SHALL force IDLE on the next edge: core_stall_n=0, no layer_done, no all_done.
REQ-018 abort together with layer_end: abort wins.
REQ-019 abort together with start in IDLE: abort wins, no run starts.
REQ-020 cfg_wr SHALL be accepted in every state; a write to the active slot SHALL NOT change the max_val_* outputs until the next LOAD of that slot.
REQ-021 Descriptor fields SHALL be stored at exactly their port widths; no arithmetic is applied to them.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, and drive core_stall_n, busy, layer_done, all_done, cur_layer and all max_val_* outputs to 0, and all descriptor slots to 0.
REQ-023 Reset mid-run SHALL behave as abort, with descriptors also cleared.

Structure
REQ-024 The sched_state_t enum and the layer_cfg_t struct (the six descriptor fields) SHALL live in basic_package.
REQ-025 The descriptor storage SHALL be one sub-module, layer_cfg_rf: an NL-entry flop register file with a synchronous write port and an asynchronous read port.

Verification
REQ-026 num_layers=3, slots 0/1/2 with cfg_done=10/20/30, start, layer_end 50 cycles into each RUN -> three layer_done pulses, max_val_cnt_done 10, 20, 30 in turn, one all_done, busy=0 afterwards.
REQ-027 Start -> core_stall_n rises exactly 2 cycles after LOAD entry; max_val_* are unchanged from the SETTLE cycle through the whole RUN.
REQ-028 num_layers=0, start -> all_done on the next cycle, core_stall_n never high, busy never high.
REQ-029 abort and layer_end in the same RUN cycle -> IDLE next cycle, no layer_done, core_stall_n=0.
REQ-030 cfg_wr to slot 1 (cfg_done=99) while slot 1 is in RUN -> output stays at its old value; the next run shows 99 for layer 1.
REQ-031 rst_n asserted mid-RUN without a clock edge -> all outputs 0 immediately; after release, start runs normally.
